// File: rtl/pattern_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : pattern_pkg                                                    |
// | Brief     : Shared constants, FSM state type and pattern-index helper for  |
// |             the HDMI test-pattern generators and their scheduler.          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package pattern_pkg;

  // Upper bound on the number of selectable pattern streams.
  localparam int MAX_PATTERNS = 8;
  // Width of every pattern index; always wide enough for MAX_PATTERNS.
  localparam int SEL_W        = $clog2(MAX_PATTERNS);

  // Colour constants ({r,g,b}) shared by all pattern generators.
  localparam logic [23:0] COLOR_BLACK   = 24'h000000;
  localparam logic [23:0] COLOR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COLOR_RED     = 24'hFF0000;
  localparam logic [23:0] COLOR_GREEN   = 24'h00FF00;
  localparam logic [23:0] COLOR_BLUE    = 24'h0000FF;
  localparam logic [23:0] COLOR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COLOR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COLOR_MAGENTA = 24'hFF00FF;

  // Scheduler states: RUN = idle/auto counting, PENDING = one switch queued.
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    PENDING = 1'b1
  } seq_state_e;

  // Next pattern index, wrapping from num-1 back to 0.
  function automatic logic [SEL_W-1:0] next_pattern(input logic [SEL_W-1:0] sel,
                                                    input int              num);
    if (int'(sel) >= num - 1) begin
      return '0;
    end
    return sel + SEL_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : pattern_seq_ctrl_if                                            |
// | Brief     : Video bundle between the pattern generators, the scheduler mux |
// |             and the encoder: per-pattern streams in, selected stream out.  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface pattern_seq_ctrl_if #(
  parameter int NUM_PATTERNS = 4
);

  // Parallel pattern streams, bit/slice i belongs to pattern i.
  logic [NUM_PATTERNS-1:0]    pat_hs;
  logic [NUM_PATTERNS-1:0]    pat_vs;
  logic [NUM_PATTERNS-1:0]    pat_de;
  logic [24*NUM_PATTERNS-1:0] pat_rgb;

  // Selected stream towards the encoder.
  logic       hs;
  logic       vs;
  logic       de;
  logic [7:0] rgb_r;
  logic [7:0] rgb_g;
  logic [7:0] rgb_b;

  // Pattern-generator / encoder side.
  modport master (
    output pat_hs, pat_vs, pat_de, pat_rgb,
    input  hs, vs, de, rgb_r, rgb_g, rgb_b
  );

  // Scheduler side.
  modport slave (
    input  pat_hs, pat_vs, pat_de, pat_rgb,
    output hs, vs, de, rgb_r, rgb_g, rgb_b
  );

endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : key_debounce                                                   |
// | Brief     : Front-panel key conditioner: 2-FF synchroniser, stability      |
// |             counter, stable level and one-cycle press strobe (1->0).       |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_q;
  logic             stable_d;
  logic             stable_prev_q;
  logic             press_q;
  logic             press_d;

  // Bring the asynchronous key level into the clk domain; idle level is released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed from the stable level for DEBOUNCE_CYCLES cycles.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Strobe on the cycle after the stable level has fallen (press, not release).
    press_d = stable_prev_q & ~stable_q;
  end

  // Debouncer state and registered press strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      stable_q      <= 1'b1;
      stable_prev_q <= 1'b1;
      press_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      press_q       <= press_d;
    end
  end

  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/pattern_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : pattern_seq_ctrl                                               |
// | Brief     : Frame-synchronous test-pattern scheduler. Selects one of       |
// |             NUM_PATTERNS streams; advances on a debounced key press or     |
// |             after FRAMES_PER_PATTERN frames, always at a frame boundary.   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module pattern_seq_ctrl
  import pattern_pkg::*;
#(
  parameter int NUM_PATTERNS       = 4,
  parameter int DEBOUNCE_CYCLES    = 1000000,
  parameter int FRAMES_PER_PATTERN = 120
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_n,
  input  logic               auto_en,
  input  logic               hold,
  input  logic               timing_vs,
  pattern_seq_ctrl_if.slave  vid,
  output logic [2:0]         pattern_sel,
  output logic               switch_pulse
);

  localparam int               FCNT_W    = $clog2(FRAMES_PER_PATTERN + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_PATTERN - 1);

  logic              press;
  logic              vs_d_q;
  logic              fe;
  logic              auto_tick;
  logic              advance;
  seq_state_e        state_q;
  seq_state_e        state_d;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic [FCNT_W-1:0] frame_cnt_d;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_d;
  logic              pulse_q;
  logic              pulse_d;
  logic              hs_q;
  logic              hs_d;
  logic              vs_q;
  logic              vs_d;
  logic              de_q;
  logic              de_d;
  logic [23:0]       rgb_q;
  logic [23:0]       rgb_d;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .press (press)
  );

  // Delay vsync by one cycle so its rising edge marks the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_q <= 1'b0;
    end else begin
      vs_d_q <= timing_vs;
    end
  end

  assign fe        = timing_vs & ~vs_d_q;
  assign auto_tick = fe & auto_en & ~hold;

  // Switch scheduling: queue one key request, count frames in auto mode, advance only on fe.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    advance     = 1'b0;
    case (state_q)
      RUN: begin
        if (press) begin
          state_d = PENDING;
        end
        if (auto_tick) begin
          if (frame_cnt_q == FCNT_LAST) begin
            advance     = 1'b1;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      PENDING: begin
        // A simultaneous auto expiry is absorbed: this one advance serves both.
        if (fe && !hold) begin
          advance     = 1'b1;
          frame_cnt_d = '0;
          state_d     = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    sel_d   = advance ? next_pattern(sel_q, NUM_PATTERNS) : sel_q;
    pulse_d = advance;
  end

  // Select the stream addressed by the registered index (one cycle of mux latency).
  always_comb begin
    hs_d  = 1'b0;
    vs_d  = 1'b0;
    de_d  = 1'b0;
    rgb_d = '0;
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        hs_d  = vid.pat_hs[i];
        vs_d  = vid.pat_vs[i];
        de_d  = vid.pat_de[i];
        rgb_d = vid.pat_rgb[24*i +: 24];
      end
    end
  end

  // Scheduler state, index, strobe and registered video outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      frame_cnt_q <= '0;
      sel_q       <= '0;
      pulse_q     <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      sel_q       <= sel_d;
      pulse_q     <= pulse_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
      rgb_q       <= rgb_d;
    end
  end

  assign pattern_sel  = sel_q;
  assign switch_pulse = pulse_q;
  assign vid.hs       = hs_q;
  assign vid.vs       = vs_q;
  assign vid.de       = de_q;
  assign vid.rgb_r    = rgb_q[23:16];
  assign vid.rgb_g    = rgb_q[15:8];
  assign vid.rgb_b    = rgb_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_pattern_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_pattern_seq_ctrl                                            |
// | Brief     : Scoreboard bench for pattern_seq_ctrl with a behavioural model |
// |             of debounce, frame scheduling and output mux.                  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_pattern_seq_ctrl;

  localparam int NP        = 4;
  localparam int DC        = 4;
  localparam int FPP       = 3;
  localparam int FRAME_LEN = 32;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    logic [2:0]  sel;
    logic        pulse;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_n;
  logic       auto_en;
  logic       hold;
  logic       timing_vs;
  logic [2:0] pattern_sel;
  logic       switch_pulse;

  pattern_seq_ctrl_if #(.NUM_PATTERNS(NP)) vid ();

  pattern_seq_ctrl #(
    .NUM_PATTERNS       (NP),
    .DEBOUNCE_CYCLES    (DC),
    .FRAMES_PER_PATTERN (FPP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_n        (key_n),
    .auto_en      (auto_en),
    .hold         (hold),
    .timing_vs    (timing_vs),
    .vid          (vid),
    .pattern_sel  (pattern_sel),
    .switch_pulse (switch_pulse)
  );

  always #5 clk = ~clk;

  // Scoreboard and bookkeeping.
  exp_t       exp_q[$];
  exp_t       last_e;
  int         checks    = 0;
  int         failures  = 0;
  int         pulse_cnt = 0;
  logic [2:0] obs_sel[$];

  // Requested input levels, applied on the next falling clock edge.
  logic rst_v, key_v, auto_v, hold_v;
  int   pos = 0;

  // Reference model state.
  bit   khist[$];
  int   press_at[$];
  bit   m_stable, m_prev_vs, m_req;
  int   m_sel, m_frames, cyc, fe_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic de_of(input int i, input int p);
    return (p >= 8) && (p < 30) && (((p + i) % 4) != 3);
  endfunction

  task automatic model_reset();
    khist.delete();
    for (int j = 0; j < DC + 2; j++) khist.push_back(1'b1);
    press_at.delete();
    m_stable  = 1'b1;
    m_prev_vs = 1'b0;
    m_req     = 1'b0;
    m_sel     = 0;
    m_frames  = 0;
  endtask

  // One clock cycle: drive stimulus at negedge and predict the outputs after the next posedge.
  task automatic tick();
    logic [NP-1:0] hs_v, vs_v, de_v;
    logic [23:0]   rgb_v[NP];
    logic          tvs, fe_m, press_now, flip, adv;
    exp_t          e;
    @(negedge clk);
    tvs = (pos < 3);
    for (int i = 0; i < NP; i++) begin
      hs_v[i]  = ((pos + i) % 5) == 0;
      vs_v[i]  = pos < (2 + i);
      de_v[i]  = de_of(i, pos);
      rgb_v[i] = 24'(32'h111111 * (i + 1));
      vid.pat_rgb[24*i +: 24] = rgb_v[i];
    end
    vid.pat_hs = hs_v;
    vid.pat_vs = vs_v;
    vid.pat_de = de_v;
    timing_vs  = tvs;
    key_n      = key_v;
    auto_en    = auto_v;
    hold       = hold_v;
    rst_n      = rst_v;
    e          = '0;
    if (!rst_v) begin
      model_reset();
    end else begin
      // Key: the level seen after synchronisation lags the pin by two cycles; it is
      // accepted once the last DC synchronised samples all disagree with the stable level.
      khist.push_back(key_v);
      void'(khist.pop_front());
      flip = 1'b1;
      for (int j = 0; j < DC; j++) if (khist[j] == m_stable) flip = 1'b0;
      if (flip) begin
        if (m_stable) press_at.push_back(cyc + 2);
        m_stable = ~m_stable;
      end
      press_now = 1'b0;
      if (press_at.size() > 0 && press_at[0] == cyc) begin
        press_now = 1'b1;
        void'(press_at.pop_front());
      end
      // Frame scheduling.
      fe_m      = tvs && !m_prev_vs;
      m_prev_vs = tvs;
      if (fe_m) fe_cnt++;
      adv = 1'b0;
      if (m_req) begin
        if (fe_m && !hold_v) begin
          adv = 1'b1; m_req = 1'b0; m_frames = 0;
        end
      end else begin
        if (fe_m && auto_v && !hold_v) begin
          if (m_frames == FPP - 1) begin adv = 1'b1; m_frames = 0; end
          else m_frames++;
        end
        if (press_now) m_req = 1'b1;
      end
      e.hs  = hs_v[m_sel];
      e.vs  = vs_v[m_sel];
      e.de  = de_v[m_sel];
      e.rgb = rgb_v[m_sel];
      if (adv) m_sel = (m_sel + 1) % NP;
      e.sel   = 3'(m_sel);
      e.pulse = adv;
    end
    exp_q.push_back(e);
    last_e = e;
    cyc++;
    pos = (pos + 1) % FRAME_LEN;
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic run_frames(input int n);
    int target;
    target = fe_cnt + n;
    for (int j = 0; j < (n + 1) * FRAME_LEN && fe_cnt < target; j++) tick();
    check("frame_budget", 32'(fe_cnt >= target), 32'd1);
    ticks(3);
  endtask

  task automatic align(input int p);
    for (int j = 0; j < FRAME_LEN && pos != p; j++) tick();
  endtask

  task automatic do_reset();
    rst_v = 1'b0;
    ticks(2);
    rst_v = 1'b1;
    ticks(1);
    pulse_cnt = 0;
    obs_sel.delete();
    fe_cnt = 0;
  endtask

  // Monitor: compare every registered output sample against the next scoreboard entry.
  initial begin : monitor
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e       = exp_q.pop_front();
        a.hs    = vid.hs;
        a.vs    = vid.vs;
        a.de    = vid.de;
        a.rgb   = {vid.rgb_r, vid.rgb_g, vid.rgb_b};
        a.sel   = pattern_sel;
        a.pulse = switch_pulse;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL out t=%0t got hs/vs/de=%b%b%b rgb=%h sel=%0d pulse=%b expected hs/vs/de=%b%b%b rgb=%h sel=%0d pulse=%b",
                   $time, a.hs, a.vs, a.de, a.rgb, a.sel, a.pulse,
                   e.hs, e.vs, e.de, e.rgb, e.sel, e.pulse);
        end
        if (switch_pulse === 1'b1) begin
          pulse_cnt++;
          obs_sel.push_back(pattern_sel);
        end
      end
    end
  end

  initial begin : driver
    int lat;
    rst_v = 1'b0; key_v = 1'b1; auto_v = 1'b0; hold_v = 1'b0;
    rst_n = 1'b1; key_n = 1'b1; auto_en = 1'b0; hold = 1'b0; timing_vs = 1'b0;
    vid.pat_hs = '0; vid.pat_vs = '0; vid.pat_de = '0; vid.pat_rgb = '0;
    cyc = 0; fe_cnt = 0;
    model_reset();

    // Asynchronous reset takes effect without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_sel", 32'(pattern_sel), 32'd0);
    check("reset_pulse", 32'(switch_pulse), 32'd0);
    check("reset_video", {vid.hs, vid.vs, vid.de, vid.rgb_r, vid.rgb_g, vid.rgb_b}, 32'd0);
    do_reset();

    // Idle: five frames with auto off, no switches.
    run_frames(5);
    check("idle_sel", 32'(pattern_sel), 32'd0);
    check("idle_pulses", 32'(pulse_cnt), 32'd0);

    // Clean press held 20 cycles mid-frame.
    do_reset();
    align(10);
    key_v = 1'b0;
    tick();
    lat = -1;
    for (int j = 1; j < 20; j++) begin
      tick();
      if (lat < 0 && dut.u_key_debounce.press === 1'b1) lat = j;
    end
    key_v = 1'b1;
    check("press_latency", 32'(lat), 32'd7);
    run_frames(1);
    check("press_sel", 32'(pattern_sel), 32'd1);
    check("press_pulses", 32'(pulse_cnt), 32'd1);

    // Bounce of 3-cycle pulses then a stable press: one advance.
    do_reset();
    align(4);
    key_v = 1'b0; ticks(3); key_v = 1'b1; ticks(2);
    key_v = 1'b0; ticks(3); key_v = 1'b1; ticks(2);
    key_v = 1'b0; ticks(10); key_v = 1'b1; ticks(4);
    run_frames(1);
    check("bounce_pulses", 32'(pulse_cnt), 32'd1);
    check("bounce_sel", 32'(pattern_sel), 32'd1);
    // Two presses inside one frame: still one advance.
    align(4);
    key_v = 1'b0; ticks(8); key_v = 1'b1; ticks(6);
    key_v = 1'b0; ticks(8); key_v = 1'b1; ticks(4);
    run_frames(1);
    check("double_press_pulses", 32'(pulse_cnt), 32'd2);
    check("double_press_sel", 32'(pattern_sel), 32'd2);

    // Auto mode for 13 frames: switches at every third boundary, wrapping 3 -> 0.
    do_reset();
    auto_v = 1'b1;
    run_frames(13);
    auto_v = 1'b0;
    check("auto_pulses", 32'(pulse_cnt), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("auto_seq%0d", k),
            32'((k < obs_sel.size()) ? obs_sel[k] : 3'h7), 32'((k + 1) % NP));
    end
    check("auto_wrap_sel", 32'(pattern_sel), 32'd0);

    // Hold: a press queues but nothing switches until hold drops.
    do_reset();
    hold_v = 1'b1;
    align(10);
    key_v = 1'b0; ticks(12); key_v = 1'b1;
    run_frames(4);
    check("hold_sel", 32'(pattern_sel), 32'd0);
    check("hold_pulses", 32'(pulse_cnt), 32'd0);
    hold_v = 1'b0;
    run_frames(1);
    check("hold_release_sel", 32'(pattern_sel), 32'd1);
    check("hold_release_pulses", 32'(pulse_cnt), 32'd1);

    // Asynchronous reset mid-frame while de is high on pattern 2.
    do_reset();
    auto_v = 1'b1;
    for (int j = 0; j < 12 * FRAME_LEN && !(last_e.sel == 3'd2 && last_e.de); j++) tick();
    auto_v = 1'b0;
    @(posedge clk);
    #2;
    check("pre_reset_de", 32'(vid.de), 32'd1);
    check("pre_reset_sel", 32'(pattern_sel), 32'd2);
    #1 rst_n = 1'b0; rst_v = 1'b0;
    #1;
    check("async_reset_sel", 32'(pattern_sel), 32'd0);
    check("async_reset_video", {vid.hs, vid.vs, vid.de, vid.rgb_r, vid.rgb_g, vid.rgb_b}, 32'd0);
    ticks(2);
    rst_v = 1'b1;
    auto_v = 1'b1;
    run_frames(4);
    auto_v = 1'b0;
    check("post_reset_sel", 32'(pattern_sel), 32'd1);

    // Randomised key, hold and auto activity against the model.
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 15) == 0) key_v = ~key_v;
      if ($urandom_range(0, 99) == 0) hold_v = ~hold_v;
      if ($urandom_range(0, 99) == 0) auto_v = ~auto_v;
      tick();
    end
    @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pattern_seq_ctrl.md
# pattern_seq_ctrl

Frame-synchronous test-pattern scheduler for the HDMI output path. It selects one of several parallel pattern-generator streams and forwards it to the encoder. The selected pattern advances on a debounced push-button press or automatically after a programmable number of frames. Every switch is deferred to a frame boundary, so no frame ever mixes two patterns.

## Interface
Parameters:
- NUM_PATTERNS, 4, number of pattern streams muxed (2..8)
- DEBOUNCE_CYCLES, 1000000, clk cycles a key level must hold stable before it is accepted
- FRAMES_PER_PATTERN, 120, frames per pattern in auto mode (≥1)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low; one clock domain only
- key_n  in  1  raw push-button, active-low, asynchronous to clk
- auto_en  in  1  1 = auto-advance every FRAMES_PER_PATTERN frames
- hold  in  1  1 = freeze the pattern: no switches, frame counter stops
- timing_vs  in  1  active-high vsync from the timing generator; rising edge = frame boundary
- pat_hs, pat_vs, pat_de  in  NUM_PATTERNS each  per-pattern sync/DE, bit i = pattern i
- pat_rgb  in  24*NUM_PATTERNS  per-pattern {r,g,b}, pattern i at bits [24i+23:24i]
- hs, vs, de  out  1  selected sync/DE, registered
- rgb_r, rgb_g, rgb_b  out  8 each  selected colour, registered
- pattern_sel  out  3  current pattern index
- switch_pulse  out  1  one-cycle strobe in the cycle pattern_sel changes

## Operation
- Key path: key_n passes through a 2-FF synchroniser, then the debouncer.
  - Debouncer counter clears whenever the synchronised level equals the stable level.
  - Otherwise it increments. At DEBOUNCE_CYCLES-1 the stable level takes the new value and the counter clears.
  - A 1→0 transition of the stable level produces a one-cycle press strobe.
- Frame edge fe = timing_vs & ~vs_d, where vs_d is a 1-cycle delay of timing_vs.
- FSM with two states:
  - RUN:
    - A press moves the FSM to PENDING.
    - On fe with auto_en & ~hold, frame_cnt increments.
    - When frame_cnt == FRAMES_PER_PATTERN-1 at fe, the pattern advances and frame_cnt clears.
  - PENDING:
    - Further presses are ignored; at most one request is queued.
    - On fe with ~hold, the pattern advances, frame_cnt clears and the FSM returns to RUN.
    - If hold is high, the request stays queued.
- Auto expiry and a pending request on the same fe advance the pattern by exactly one.
- Advance rule: pattern_sel wraps from NUM_PATTERNS-1 to 0. Only the low clog2(NUM_PATTERNS) bits are active; the upper bits are 0.
- Clearing auto_en holds frame_cnt at its current value.
- While hold is high: frame_cnt is frozen, a press still queues a request, and no switch occurs.
- Output mux: hs/vs/de/rgb <= the stream indexed by the registered pattern_sel.
- Reset (asserted at any time, including mid-frame): pattern_sel=0, FSM=RUN, frame_cnt=0, debouncer stable level=1 (released) with its counter cleared, switch_pulse=0, hs=vs=de=0, rgb=0. All values apply immediately and asynchronously.

## Timing
- Mux latency is 1 cycle: outputs at cycle n+1 reflect the pat_* inputs at cycle n.
- Switch: pattern_sel updates at the clock edge ending the fe cycle, with switch_pulse high for that one following cycle. Outputs from the new pattern appear one further cycle later. Because fe falls in vertical blanking, de is low across the switch.
- Press latency: key_n low to press strobe = 2 (synchroniser) + DEBOUNCE_CYCLES + 1 cycles. The visible switch then waits for the next fe.
- A press arriving in the fe cycle itself is queued for the following frame.
- Bounce shorter than DEBOUNCE_CYCLES produces no press.
- Holding the key down produces exactly one press.

## Structure
- Shared package pattern_pkg holds:
  - the colour constants used by all pattern generators
  - the MAX_PATTERNS=8 constant
  - the FSM state enum {RUN, PENDING}
- The debouncer is a separate sub-module, key_debounce: synchroniser, counter, stable level and press strobe. It is reused for other front-panel keys.
- Frame-edge detection, FSM, frame counter and output mux stay in pattern_seq_ctrl.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, FRAMES_PER_PATTERN=3, NUM_PATTERNS=4. Stream i drives rgb=0x111111*(i+1) with de toggled.
- Reset release with auto_en=0 and 5 frames applied -> pattern_sel stays 0, rgb=0x111111 when de is high, no switch_pulse.
- Clean key press (held 20 cycles) mid-frame -> press exactly 7 cycles after key_n falls; pattern_sel=1 one cycle after the next fe; switch_pulse high for 1 cycle; no de-high cycle mixes two colours.
- Key bounce with 3-cycle pulses, then a stable press -> exactly one advance; two presses within one frame -> still one advance.
- auto_en=1 for 13 frames -> pattern_sel sequence 0,1,2,3,0 with a switch every 3rd fe; wrap 3→0 checked.
- hold=1 with a press and 4 frames, then hold=0 -> no change while hold is high; pattern_sel advances by one on the first fe after release.
- rst_n pulsed low while de=1 and pattern_sel=2 -> outputs go 0 and pattern_sel goes 0 asynchronously; normal operation resumes after release.
